// File: rtl/prim_subreg_pkg.sv
// Shared types for the subreg slice and its hardware update scheduler.
package prim_subreg_pkg;

    typedef enum logic [2:0] {
        SwAccessRW  = 3'd0,
        SwAccessRO  = 3'd1,
        SwAccessWO  = 3'd2,
        SwAccessW1C = 3'd3,
        SwAccessW1S = 3'd4,
        SwAccessW0C = 3'd5,
        SwAccessRC  = 3'd6
    } sw_access_e;

    typedef enum logic {
        EMPTY = 1'b0,
        ISSUE = 1'b1
    } sched_state_e;

    // Wrappers use this in an elaboration-time check before instantiating the scheduler.
    function automatic logic sched_access_ok(sw_access_e acc);
        return (acc == SwAccessRW) || (acc == SwAccessWO) || (acc == SwAccessRO);
    endfunction

    function automatic int unsigned idx_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prim_subreg_sched_if.sv
// Requester-side bundle: masked update requests in, one-hot grant and commit pulses out.
interface prim_subreg_sched_if #(
    parameter int NumReq = 4,
    parameter int DW     = 32
);
    // Handshake: an update is accepted in the cycle req_i[i] & gnt_o[i]; req_i,
    // mask_i and val_i stay stable until then. done_o[i] pulses once when it commits.
    logic [NumReq-1:0]         req_i;
    logic [NumReq-1:0][DW-1:0] mask_i;
    logic [NumReq-1:0][DW-1:0] val_i;
    logic [NumReq-1:0]         gnt_o;
    logic [NumReq-1:0]         done_o;

    modport master (output req_i, mask_i, val_i, input gnt_o, done_o);
    modport slave  (input req_i, mask_i, val_i, output gnt_o, done_o);
endinterface

// File: rtl/prim_rr_arb.sv
// Combinational round-robin arbiter; the search starts just after last.
module prim_rr_arb
    import prim_subreg_pkg::*;
#(
    parameter int N    = 4,
    parameter int IdxW = idx_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] last,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] gnt_idx
);

    always_comb begin
        int   idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 1; off <= N; off++) begin
            idx = int'(last) + off;
            if (idx >= N) idx = idx - N;
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IdxW'(idx);
            end
        end
    end

endmodule

// File: rtl/prim_subreg_sched.sv
// Single-entry scheduler putting masked hardware updates onto a subreg de/d port,
// replaying any update that loses to a same-cycle software write.
module prim_subreg_sched
    import prim_subreg_pkg::*;
#(
    parameter int DW        = 32,
    parameter int NumReq    = 4,
    parameter int StarveMax = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    prim_subreg_sched_if.slave   req_bus,
    input  logic                 sw_we_i,
    input  logic [DW-1:0]        q_i,
    output logic                 de_o,
    output logic [DW-1:0]        d_o,
    output logic                 busy_o,
    output logic                 starve_o,
    input  logic                 starve_clr_i,
    output sched_state_e         state_o
);

    localparam int IdxW   = idx_w(NumReq);
    localparam int RetryW = $clog2(StarveMax + 1);

    sched_state_e      state_q, state_d;
    logic [DW-1:0]     mask_q, mask_d, val_q, val_d;
    logic [IdxW-1:0]   owner_q, owner_d, last_q, last_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic              starve_q, starve_d;

    logic              valid, commit, lost, load_ok, any_gnt;
    logic [NumReq-1:0] gnt, done;
    logic [IdxW-1:0]   gnt_idx;

    assign valid   = (state_q == ISSUE);
    assign commit  = valid & ~sw_we_i;
    assign lost    = valid & sw_we_i;
    assign load_ok = ~valid | commit;
    assign any_gnt = |gnt;

    prim_rr_arb #(.N(NumReq), .IdxW(IdxW)) u_arb (
        .req     (req_bus.req_i),
        .last    (last_q),
        .en      (load_ok),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        val_d    = val_q;
        owner_d  = owner_q;
        last_d   = last_q;
        retry_d  = retry_q;
        starve_d = starve_q;
        done     = '0;

        if (lost) begin
            if (retry_q != RetryW'(StarveMax)) retry_d = retry_q + 1'b1;
        end
        if (commit) begin
            done[owner_q] = 1'b1;
            retry_d       = '0;
            state_d       = EMPTY;
        end
        if (any_gnt) begin
            state_d = ISSUE;
            mask_d  = req_bus.mask_i[gnt_idx];
            val_d   = req_bus.val_i[gnt_idx];
            owner_d = gnt_idx;
            last_d  = gnt_idx;
        end

        // Set wins over a same-cycle clear.
        if (lost && (retry_q >= RetryW'(StarveMax - 1))) starve_d = 1'b1;
        else if (starve_clr_i)                          starve_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= EMPTY;
            mask_q   <= '0;
            val_q    <= '0;
            owner_q  <= '0;
            last_q   <= IdxW'(NumReq - 1);
            retry_q  <= '0;
            starve_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            val_q    <= val_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            retry_q  <= retry_d;
            starve_q <= starve_d;
        end
    end

    // d_o merges against the live q_i so a replay sees the software-written value.
    assign d_o             = (q_i & ~mask_q) | (val_q & mask_q);
    assign de_o            = valid;
    assign busy_o          = valid;
    assign starve_o        = starve_q;
    assign state_o         = state_q;
    assign req_bus.gnt_o   = gnt;
    assign req_bus.done_o  = done;

endmodule

// File: tb/tb_prim_subreg_sched.sv
// Directed bench for prim_subreg_sched with a small subreg model closing the q loop.
module tb_prim_subreg_sched;
    import prim_subreg_pkg::*;

    localparam int DW = 32;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          sw_we;
    logic [DW-1:0] sw_data;
    logic [DW-1:0] q_reg;
    logic          de;
    logic [DW-1:0] d;
    logic          busy, starve, starve_clr;
    sched_state_e  state;

    int checks = 0;
    int errors = 0;

    prim_subreg_sched_if #(.NumReq(NR), .DW(DW)) bus ();

    prim_subreg_sched #(.DW(DW), .NumReq(NR), .StarveMax(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_bus      (bus),
        .sw_we_i      (sw_we),
        .q_i          (q_reg),
        .de_o         (de),
        .d_o          (d),
        .busy_o       (busy),
        .starve_o     (starve),
        .starve_clr_i (starve_clr),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    // Subreg model: software write wins over the hardware update.
    always_ff @(posedge clk) begin
        if (rst)        q_reg <= '0;
        else if (sw_we) q_reg <= sw_data;
        else if (de)    q_reg <= d;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [NR-1:0] rr_gnt [5];
    logic [NR-1:0] rr_done[5];
    logic [DW-1:0] rr_d   [5];

    initial begin
        rst = 1'b1; sw_we = 1'b0; sw_data = '0; starve_clr = 1'b0;
        bus.req_i = '0; bus.mask_i = '0; bus.val_i = '0;
        cyc(); cyc();

        // Reset state
        chk("rst_de", 64'(de), 0);
        chk("rst_gnt", 64'(bus.gnt_o), 0);
        chk("rst_done", 64'(bus.done_o), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_starve", 64'(starve), 0);
        chk("rst_d", 64'(d), 0);
        chk("rst_state", 64'(state), 64'(EMPTY));
        rst = 1'b0;
        cyc();

        // Software write while EMPTY is ignored by the scheduler
        sw_we = 1'b1; sw_data = 32'h0000_00F0;
        #1;
        chk("swe_empty_busy", 64'(busy), 0);
        chk("swe_empty_gnt", 64'(bus.gnt_o), 0);
        cyc();
        sw_we = 1'b0;

        // Single request from requester 2
        bus.req_i[2] = 1'b1; bus.mask_i[2] = 32'h0F; bus.val_i[2] = 32'h05;
        #1;
        chk("single_gnt", 64'(bus.gnt_o), 64'b0100);
        cyc();
        bus.req_i[2] = 1'b0;
        #1;
        chk("single_de", 64'(de), 1);
        chk("single_d", 64'(d), 64'h0F5);
        chk("single_done", 64'(bus.done_o), 64'b0100);
        chk("single_state", 64'(state), 64'(ISSUE));
        cyc();
        chk("single_idle_de", 64'(de), 0);
        chk("single_idle_done", 64'(bus.done_o), 0);

        // Round-robin from reset, all four held
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < NR; i++) begin
            bus.mask_i[i] = 32'(1) << i;
            bus.val_i[i]  = 32'(1) << i;
        end
        bus.req_i = 4'hF;
        rr_gnt[0] = 4'b0001; rr_done[0] = 4'b0000; rr_d[0] = 32'h0;
        rr_gnt[1] = 4'b0010; rr_done[1] = 4'b0001; rr_d[1] = 32'h1;
        rr_gnt[2] = 4'b0100; rr_done[2] = 4'b0010; rr_d[2] = 32'h3;
        rr_gnt[3] = 4'b1000; rr_done[3] = 4'b0100; rr_d[3] = 32'h7;
        rr_gnt[4] = 4'b0001; rr_done[4] = 4'b1000; rr_d[4] = 32'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr_gnt%0d", k), 64'(bus.gnt_o), 64'(rr_gnt[k]));
            chk($sformatf("rr_done%0d", k), 64'(bus.done_o), 64'(rr_done[k]));
            if (k > 0) begin
                chk($sformatf("rr_de%0d", k), 64'(de), 1);
                chk($sformatf("rr_d%0d", k), 64'(d), 64'(rr_d[k]));
            end
            cyc();
        end
        bus.req_i = '0;
        #1;
        chk("rr_last_done", 64'(bus.done_o), 64'b0001);
        chk("rr_last_gnt", 64'(bus.gnt_o), 0);
        cyc();
        chk("rr_idle_de", 64'(de), 0);

        // Software collision: q=0xF, entry mask 0xFF val 0xAA from requester 0
        bus.req_i[0] = 1'b1; bus.mask_i[0] = 32'hFF; bus.val_i[0] = 32'hAA;
        #1;
        chk("col_gnt0", 64'(bus.gnt_o), 64'b0001);
        cyc();
        bus.req_i[0] = 1'b0;
        bus.req_i[1] = 1'b1; bus.mask_i[1] = 32'hF00; bus.val_i[1] = 32'h500;
        sw_we = 1'b1; sw_data = 32'h1234;
        #1;
        chk("col_lost_done", 64'(bus.done_o), 0);
        chk("col_lost_gnt", 64'(bus.gnt_o), 0);
        chk("col_lost_de", 64'(de), 1);
        chk("col_lost_d", 64'(d), 64'hAA);
        cyc();
        sw_we = 1'b0;
        #1;
        chk("col_replay_d", 64'(d), 64'h12AA);
        chk("col_replay_done", 64'(bus.done_o), 64'b0001);
        chk("col_next_gnt", 64'(bus.gnt_o), 64'b0010);
        cyc();
        bus.req_i[1] = 1'b0;
        #1;
        chk("col_b2b_d", 64'(d), 64'h15AA);
        chk("col_b2b_done", 64'(bus.done_o), 64'b0010);
        cyc();
        chk("col_idle_busy", 64'(busy), 0);
        chk("col_starve", 64'(starve), 0);

        // Starvation with StarveMax=2
        bus.req_i[2] = 1'b1; bus.mask_i[2] = 32'hFF; bus.val_i[2] = 32'h3C;
        #1;
        chk("stv_gnt", 64'(bus.gnt_o), 64'b0100);
        cyc();
        bus.req_i[2] = 1'b0;
        sw_we = 1'b1; sw_data = 32'h0;
        #1;
        chk("stv_lost1", 64'(starve), 0);
        cyc();
        chk("stv_lost2", 64'(starve), 0);
        chk("stv_lost2_done", 64'(bus.done_o), 0);
        cyc();
        starve_clr = 1'b1;
        #1;
        chk("stv_set", 64'(starve), 1);
        chk("stv_lost3_done", 64'(bus.done_o), 0);
        cyc();
        starve_clr = 1'b0; sw_we = 1'b0;
        #1;
        chk("stv_set_wins", 64'(starve), 1);
        chk("stv_done", 64'(bus.done_o), 64'b0100);
        chk("stv_d", 64'(d), 64'h3C);
        cyc();
        chk("stv_hold", 64'(starve), 1);
        starve_clr = 1'b1;
        cyc();
        starve_clr = 1'b0;
        chk("stv_clr", 64'(starve), 0);

        // Reset while ISSUE
        bus.req_i[3] = 1'b1; bus.mask_i[3] = 32'hFF00; bus.val_i[3] = 32'h2200;
        #1;
        chk("rmid_gnt", 64'(bus.gnt_o), 64'b1000);
        cyc();
        chk("rmid_issue", 64'(state), 64'(ISSUE));
        rst = 1'b1;
        bus.req_i[0] = 1'b1; bus.mask_i[0] = 32'hFF; bus.val_i[0] = 32'h11;
        cyc();
        rst = 1'b0;
        #1;
        chk("rmid_de", 64'(de), 0);
        chk("rmid_done", 64'(bus.done_o), 0);
        chk("rmid_first_gnt", 64'(bus.gnt_o), 64'b0001);
        cyc();
        bus.req_i[0] = 1'b0;
        #1;
        chk("rmid_done0", 64'(bus.done_o), 64'b0001);
        chk("rmid_d0", 64'(d), 64'h11);
        chk("rmid_gnt3", 64'(bus.gnt_o), 64'b1000);
        cyc();
        bus.req_i[3] = 1'b0;
        #1;
        chk("rmid_done3", 64'(bus.done_o), 64'b1000);
        chk("rmid_d3", 64'(d), 64'h2211);
        cyc();

        // Back-to-back requesters 1 and 3 with q tracking commits
        bus.req_i[1] = 1'b1; bus.mask_i[1] = 32'h0000_FFFF; bus.val_i[1] = 32'h0000_BEEF;
        bus.req_i[3] = 1'b1; bus.mask_i[3] = 32'h00FF_0F00; bus.val_i[3] = 32'h0055_0C00;
        #1;
        chk("b2b_gnt1", 64'(bus.gnt_o), 64'b0010);
        cyc();
        bus.req_i[1] = 1'b0;
        #1;
        chk("b2b_done1", 64'(bus.done_o), 64'b0010);
        chk("b2b_d1", 64'(d), 64'hBEEF);
        chk("b2b_gnt3", 64'(bus.gnt_o), 64'b1000);
        cyc();
        bus.req_i[3] = 1'b0;
        #1;
        chk("b2b_done3", 64'(bus.done_o), 64'b1000);
        chk("b2b_d3", 64'(d), 64'h0055_BCEF);
        chk("b2b_de", 64'(de), 1);
        cyc();
        chk("b2b_idle", 64'(de), 0);
        chk("b2b_q", 64'(q_reg), 64'h0055_BCEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
